// File: rtl/cpu_bus_ctrl_pkg.sv
// cpu_bus_ctrl shared definitions.
// FSM encoding, error cause codes and the default slot map.
package cpu_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNMAPPED  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
    localparam logic [1:0] ERR_VIOLATION = 2'd3;

    // Slot 0 sits in the low byte: slots 0..7 = 00,40,c0,c1,c2,c3,d0,ff.
    localparam logic [63:0] DEF_PREFIXES  = 64'hffd0_c3c2_c1c0_4000;
    localparam logic [7:0]  DEF_SYS_MASK  = 8'b0100_0100;
    localparam logic [31:0] DEF_ILLEGAL   = 32'h0;

endpackage

// File: rtl/cpu_bus_ctrl_decoder.sv
// cpu_bus_ctrl address prefix decoder.
// Pure combinational lookup of cpu_addr[31:24] in the slot table.
module cpu_bus_decoder #(
    parameter int                    NUM_SLOTS     = 8,
    parameter int                    IW            = 3,
    parameter logic [NUM_SLOTS*8-1:0] SLOT_PREFIXES = 64'hffd0_c3c2_c1c0_4000,
    parameter logic [NUM_SLOTS-1:0]  SYS_ONLY_MASK = 8'b0100_0100
) (
    input  logic [7:0]    i_prefix,
    input  logic          i_system_mode,
    output logic          o_hit,
    output logic [IW-1:0] o_sel_idx,
    output logic          o_violation
);

    logic w_sys_only;

    // Scan high to low so the lowest matching slot is the one kept.
    always_comb begin
        o_hit      = 1'b0;
        o_sel_idx  = '0;
        w_sys_only = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (i_prefix == SLOT_PREFIXES[8*i +: 8]) begin
                o_hit      = 1'b1;
                o_sel_idx  = IW'(i);
                w_sys_only = SYS_ONLY_MASK[i];
            end
        end
        o_violation = o_hit && w_sys_only && !i_system_mode;
    end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: picorv32 native bus to NUM_SLOTS target cores.
// Prefix decode, registered handshake, timeout and access protection.
module cpu_bus_ctrl
    import cpu_bus_ctrl_pkg::*;
#(
    parameter int                     NUM_SLOTS           = 8,
    parameter logic [NUM_SLOTS*8-1:0] SLOT_PREFIXES       = DEF_PREFIXES,
    parameter logic [NUM_SLOTS-1:0]   SYS_ONLY_MASK       = DEF_SYS_MASK,
    parameter int                     TIMEOUT_CYCLES      = 255,
    parameter logic [31:0]            ILLEGAL_INSTRUCTION = DEF_ILLEGAL
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cpu_valid,
    input  logic [31:0]               cpu_addr,
    input  logic [3:0]                cpu_wstrb,
    input  logic [31:0]               cpu_wdata,
    output logic                      cpu_ready,
    output logic [31:0]               cpu_rdata,
    input  logic                      system_mode,
    input  logic                      force_trap,
    output logic [NUM_SLOTS-1:0]      slot_cs,
    output logic [3:0]                slot_we,
    output logic [15:0]               slot_address,
    output logic [31:0]               slot_wdata,
    input  logic [NUM_SLOTS*32-1:0]   slot_rdata,
    input  logic [NUM_SLOTS-1:0]      slot_ready,
    output logic                      bus_error,
    output logic [1:0]                error_cause,
    output logic [31:0]               error_addr
);

    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLIM =
        TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMAX = '1;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_sel;
    logic [TW-1:0]   r_timer;
    logic [31:0]     r_rdata;
    logic            r_berr;
    logic [1:0]      r_cause;
    logic [31:0]     r_eaddr;

    logic            w_hit;
    logic            w_viol;
    logic [IW-1:0]   w_sel;
    logic            w_take;
    logic            w_load;
    logic [31:0]     w_load_val;
    logic            w_err;
    logic [1:0]      w_cause;
    logic [NUM_SLOTS-1:0] w_cs;
    logic [3:0]      w_we;

    cpu_bus_decoder #(
        .NUM_SLOTS     (NUM_SLOTS),
        .IW            (IW),
        .SLOT_PREFIXES (SLOT_PREFIXES),
        .SYS_ONLY_MASK (SYS_ONLY_MASK)
    ) u_dec (
        .i_prefix      (cpu_addr[31:24]),
        .i_system_mode (system_mode),
        .o_hit         (w_hit),
        .o_sel_idx     (w_sel),
        .o_violation   (w_viol)
    );

    // State register; async reset drops chip selects immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state, slot strobes and datapath load controls.
    always_comb begin
        w_next     = r_state;
        w_take     = 1'b0;
        w_load     = 1'b0;
        w_load_val = ILLEGAL_INSTRUCTION;
        w_err      = 1'b0;
        w_cause    = ERR_NONE;
        w_cs       = '0;
        w_we       = '0;
        case (r_state)
            IDLE: begin
                if (cpu_valid) begin
                    if (force_trap) begin
                        w_load = 1'b1;
                        w_next = RESP;
                    end else if (!w_hit) begin
                        w_load  = 1'b1;
                        w_err   = 1'b1;
                        w_cause = ERR_UNMAPPED;
                        w_next  = RESP;
                    end else if (w_viol) begin
                        w_load  = 1'b1;
                        w_err   = 1'b1;
                        w_cause = ERR_VIOLATION;
                        w_next  = RESP;
                    end else begin
                        w_take = 1'b1;
                        w_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                w_cs = NUM_SLOTS'(1) << r_sel;
                w_we = cpu_wstrb;
                if (slot_ready[r_sel]) begin
                    w_load     = 1'b1;
                    w_load_val = slot_rdata[r_sel*32 +: 32];
                    w_next     = RESP;
                end else if (TIMEOUT_CYCLES != 0 && r_timer == TLIM) begin
                    w_load  = 1'b1;
                    w_err   = 1'b1;
                    w_cause = ERR_TIMEOUT;
                    w_next  = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: slot select, wait timer, response data and error log.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel   <= '0;
            r_timer <= '0;
            r_rdata <= '0;
            r_berr  <= 1'b0;
            r_cause <= ERR_NONE;
            r_eaddr <= '0;
        end else begin
            r_berr <= w_err;
            if (w_take) begin
                r_sel   <= w_sel;
                r_timer <= '0;
            end else if (r_state == ACCESS && r_timer != TMAX) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_load) r_rdata <= w_load_val;
            if (w_err) begin
                r_cause <= w_cause;
                r_eaddr <= cpu_addr;
            end
        end
    end

    assign cpu_ready    = (r_state == RESP);
    assign cpu_rdata    = r_rdata;
    assign slot_cs      = w_cs;
    assign slot_we      = w_we;
    assign slot_address = cpu_addr[17:2];
    assign slot_wdata   = cpu_wdata;
    assign bus_error    = r_berr;
    assign error_cause  = r_cause;
    assign error_addr   = r_eaddr;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl.
// Transaction-level reference model with a behavioural slot responder.
module tb_cpu_bus_ctrl;

    localparam int N   = 8;
    localparam int TMO = 4;
    localparam logic [63:0] PFX  = 64'hffd0_c3c2_c1c0_4000;
    localparam logic [7:0]  SYSM = 8'b0100_0100;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            cpu_valid = 1'b0;
    logic [31:0]     cpu_addr = '0;
    logic [3:0]      cpu_wstrb = '0;
    logic [31:0]     cpu_wdata = '0;
    logic            cpu_ready;
    logic [31:0]     cpu_rdata;
    logic            system_mode = 1'b0;
    logic            force_trap = 1'b0;
    logic [N-1:0]    slot_cs;
    logic [3:0]      slot_we;
    logic [15:0]     slot_address;
    logic [31:0]     slot_wdata;
    logic [N*32-1:0] slot_rdata = '0;
    logic [N-1:0]    slot_ready;
    logic            bus_error;
    logic [1:0]      error_cause;
    logic [31:0]     error_addr;

    int total = 0;
    int bad   = 0;
    int dly   = 0;
    int cnt;
    logic [1:0]  last_cause = 2'd0;
    logic [31:0] last_eaddr = 32'h0;

    cpu_bus_ctrl #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_valid    (cpu_valid),
        .cpu_addr     (cpu_addr),
        .cpu_wstrb    (cpu_wstrb),
        .cpu_wdata    (cpu_wdata),
        .cpu_ready    (cpu_ready),
        .cpu_rdata    (cpu_rdata),
        .system_mode  (system_mode),
        .force_trap   (force_trap),
        .slot_cs      (slot_cs),
        .slot_we      (slot_we),
        .slot_address (slot_address),
        .slot_wdata   (slot_wdata),
        .slot_rdata   (slot_rdata),
        .slot_ready   (slot_ready),
        .bus_error    (bus_error),
        .error_cause  (error_cause),
        .error_addr   (error_addr)
    );

    always #5 clk = ~clk;

    // Slot responder: ready once chip select has been held dly cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     cnt <= 0;
        else if (|slot_cs) cnt <= cnt + 1;
        else              cnt <= 0;
    end

    always_comb slot_ready = (cnt >= dly) ? slot_cs : '0;

    task automatic do_access(input string nm, input logic [31:0] addr,
                             input logic [3:0] ws, input logic sys,
                             input logic trap, input int d, input bit drop);
        int          slot;
        int          exp_lat;
        int          exp_csn;
        int          exp_slot;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [N-1:0] exp_cs;
        logic [31:0] wd[N];
        logic [31:0] wdat;
        int          csn;
        bit          got;
        int          lat;
        slot = -1;
        for (int i = 0; i < N; i++)
            if (slot < 0 && addr[31:24] == PFX[8*i +: 8]) slot = i;
        for (int i = 0; i < N; i++) wd[i] = $urandom;
        wdat     = $urandom;
        exp_slot = -1;
        exp_err  = 1'b0;
        exp_rd   = 32'h0;
        exp_csn  = 0;
        exp_lat  = 1;
        if (trap) begin
        end else if (slot < 0) begin
            exp_err = 1'b1; last_cause = 2'd1; last_eaddr = addr;
        end else if (SYSM[slot] && !sys) begin
            exp_err = 1'b1; last_cause = 2'd3; last_eaddr = addr;
        end else if (d < TMO) begin
            exp_slot = slot; exp_csn = d + 1; exp_lat = d + 2;
            exp_rd = wd[slot];
        end else begin
            exp_slot = slot; exp_csn = TMO; exp_lat = TMO + 1;
            exp_err = 1'b1; last_cause = 2'd2; last_eaddr = addr;
        end
        exp_cs = '0;
        if (exp_slot >= 0) exp_cs[exp_slot] = 1'b1;

        @(negedge clk);
        for (int i = 0; i < N; i++) slot_rdata[32*i +: 32] = wd[i];
        dly = d;
        cpu_addr = addr; cpu_wstrb = ws; cpu_wdata = wdat;
        system_mode = sys; force_trap = trap; cpu_valid = 1'b1;
        csn = 0; got = 0; lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk); #1;
            if (drop && k == 1) begin
                cpu_valid = 1'b0; system_mode = 1'b0;
            end
            if (|slot_cs) begin
                csn++;
                total++;
                if (slot_cs !== exp_cs) begin
                    bad++;
                    $display("FAIL %s cs: got %b want %b", nm, slot_cs, exp_cs);
                end
                total++;
                if (slot_we !== ws || slot_address !== addr[17:2] ||
                    slot_wdata !== wdat) begin
                    bad++;
                    $display("FAIL %s slot_bus: we=%h adr=%h wd=%h want %h %h %h",
                             nm, slot_we, slot_address, slot_wdata,
                             ws, addr[17:2], wdat);
                end
            end
            if (cpu_ready) begin
                got = 1; lat = k;
                total++;
                if (cpu_rdata !== exp_rd) begin
                    bad++;
                    $display("FAIL %s rdata: got %h want %h", nm, cpu_rdata, exp_rd);
                end
                total++;
                if (bus_error !== exp_err) begin
                    bad++;
                    $display("FAIL %s bus_error: got %b want %b", nm, bus_error, exp_err);
                end
                total++;
                if (error_cause !== last_cause || error_addr !== last_eaddr) begin
                    bad++;
                    $display("FAIL %s err_log: got %0d/%h want %0d/%h", nm,
                             error_cause, error_addr, last_cause, last_eaddr);
                end
                cpu_valid = 1'b0; force_trap = 1'b0;
            end else begin
                total++;
                if (bus_error !== 1'b0) begin
                    bad++;
                    $display("FAIL %s bus_error_early: got 1 want 0", nm);
                end
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s ready_timeout: got none want ready", nm);
            cpu_valid = 1'b0;
        end
        total++;
        if (lat !== exp_lat || csn !== exp_csn) begin
            bad++;
            $display("FAIL %s timing: lat=%0d cs=%0d want %0d %0d", nm,
                     lat, csn, exp_lat, exp_csn);
        end
        @(posedge clk); #1;
        total++;
        if (cpu_ready !== 1'b0 || bus_error !== 1'b0) begin
            bad++;
            $display("FAIL %s one_cycle: ready=%b err=%b want 0 0", nm,
                     cpu_ready, bus_error);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({cpu_ready, bus_error, slot_cs, slot_we} !== '0 ||
            cpu_rdata !== 32'h0 || error_cause !== 2'd0 || error_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset: rdy=%b err=%b cs=%b we=%b rd=%h c=%0d a=%h want 0",
                     cpu_ready, bus_error, slot_cs, slot_we, cpu_rdata,
                     error_cause, error_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_read_comb();
        do_access("read_c3", 32'hc300_0004, 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_write_delay();
        do_access("write_40", 32'h4000_0010, 4'b0011, 1'b0, 1'b0, 3, 1'b0);
    endtask

    task automatic test_unmapped();
        do_access("unmapped", 32'h8000_0000, 4'b0000, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_sys_only();
        do_access("viol_d0", 32'hd000_0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0);
        do_access("sys_d0", 32'hd000_0000, 4'b0000, 1'b1, 1'b0, 1, 1'b0);
        do_access("sys_c0_drop", 32'hc000_0008, 4'b1111, 1'b1, 1'b0, 2, 1'b1);
    endtask

    task automatic test_timeout();
        do_access("timeout", 32'hc100_0000, 4'b0000, 1'b0, 1'b0, 255, 1'b0);
        do_access("ready_at_limit", 32'hff00_0100, 4'b0000, 1'b0, 1'b0, 3, 1'b0);
        do_access("late_ready", 32'h0000_0200, 4'b0001, 1'b0, 1'b0, 4, 1'b0);
    endtask

    task automatic test_force_trap();
        do_access("trap_rom", 32'h0000_0000, 4'b0000, 1'b1, 1'b1, 0, 1'b0);
        do_access("trap_unmapped", 32'h7700_0000, 4'b0000, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          d;
        int          pick;
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 9);
            a = $urandom;
            if (pick < 8) a[31:24] = PFX[8*pick +: 8];
            d = $urandom_range(0, 6);
            if (d == 6) d = 255;
            do_access("random", a, 4'($urandom), 1'($urandom),
                      ($urandom_range(0, 7) == 0), d, ($urandom_range(0, 5) == 0));
        end
    endtask

    task automatic test_reset_mid_access();
        do_access("pre_err", 32'h9900_0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        dly = 255;
        cpu_addr = 32'h4000_0000; force_trap = 1'b0; cpu_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (slot_cs !== 8'b0000_0010) begin
            bad++;
            $display("FAIL mid_reset_pre: cs=%b want 00000010", slot_cs);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (slot_cs !== '0 || cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_async: cs=%b rdy=%b want 0 0", slot_cs, cpu_ready);
        end
        cpu_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        last_cause = 2'd0; last_eaddr = 32'h0;
        #1;
        total++;
        if (error_cause !== 2'd0 || error_addr !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_log: c=%0d a=%h want 0 0", error_cause, error_addr);
        end
        do_access("post_reset", 32'hc300_0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read_comb();
        test_write_delay();
        test_unmapped();
        test_sys_only();
        test_timeout();
        test_force_trap();
        test_random();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
